// File: rtl/seg_scan_rx.sv
// seg_scan_rx - receive-side decoder for a four-digit multiplexed
// seven-segment scan bus.
//
// The block samples the active-low digit enables and segment byte, and
// accepts an (en, num) pair once it has been stable for STABLE_CYCLES
// samples. It maps each accepted segment pattern back to BCD and collects
// the four digits into a frame. The completed frame is converted to binary
// by a short multiply-accumulate sequence, and the result is published with
// a one-cycle frame_valid pulse.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to accept a pair (2..255)
//   TIMEOUT_CYCLES clocks without an accepted digit before stalled asserts (16..65535)
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en[3:0]      digit enables, active-low, en[0] = units .. en[3] = thousands
//   num[7:0]     segments, active-low, num[0] = a .. num[6] = g, num[7] = dp
//   digits[15:0] BCD frame {thousands, hundreds, tens, units}, 4'hF = undecodable
//   value[13:0]  binary value of digits, 0 when bad
//   dp[3:0]      decimal point per digit, 1 = lit
//   bad          frame holds at least one undecodable digit
//   frame_valid  one-cycle pulse when the frame outputs update
//   stalled      no digit accepted for TIMEOUT_CYCLES clocks
//   err_cnt[7:0] saturating count of illegal enables and unknown patterns
module seg_scan_rx #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  en,
  input  logic [7:0]  num,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic [3:0]  dp,
  output logic        bad,
  output logic        frame_valid,
  output logic        stalled,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CONV    = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [7:0]  LP_STABLE = 8'(STABLE_CYCLES);
  localparam logic [15:0] LP_TMO    = 16'(TIMEOUT_CYCLES);

  // Active-low segment pattern (a..g) to BCD; anything else is 4'hF.
  function automatic logic [3:0] f_seg_decode(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      7'h40:   d = 4'd0;
      7'h79:   d = 4'd1;
      7'h24:   d = 4'd2;
      7'h30:   d = 4'd3;
      7'h19:   d = 4'd4;
      7'h12:   d = 4'd5;
      7'h02:   d = 4'd6;
      7'h78:   d = 4'd7;
      7'h00:   d = 4'd8;
      7'h10:   d = 4'd9;
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  // True when any nibble of a BCD frame is the undecodable marker.
  function automatic logic f_any_bad(input logic [15:0] d);
    return (d[15:12] == 4'hF) || (d[11:8] == 4'hF) ||
           (d[7:4] == 4'hF) || (d[3:0] == 4'hF);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_s_en;
  logic [7:0]  r_s_num;
  logic [7:0]  r_stab_cnt;
  logic [15:0] r_idle;
  logic [15:0] r_slot_dig;
  logic [3:0]  r_slot_dp;
  logic [3:0]  r_mask;
  logic [15:0] r_f_dig;
  logic [3:0]  r_f_dp;
  logic        r_f_bad;
  logic [13:0] r_acc;
  logic [1:0]  r_step;

  logic        w_same;
  logic        w_accept;
  logic        w_blank;
  logic        w_legal;
  logic [1:0]  w_idx;
  logic [3:0]  w_bcd;
  logic        w_dig_acc;
  logic        w_wr;
  logic        w_err_inc;
  logic [3:0]  w_wr_bit;
  logic        w_mask_full;
  logic        w_start;
  logic        w_slot_we;
  logic        w_tmo_hit;
  logic [15:0] w_merge_dig;
  logic [3:0]  w_merge_dp;
  logic [15:0] w_frame_dig;
  logic [3:0]  w_frame_dp;
  logic [3:0]  w_conv_dig;
  logic [13:0] w_acc_nxt;

  // Compare the incoming pair against the registered sample; the pair is
  // accepted on the edge where its run length reaches STABLE_CYCLES.
  always_comb begin
    w_same   = (en == r_s_en) && (num == r_s_num);
    w_accept = w_same && (r_stab_cnt == (LP_STABLE - 8'd1));
    w_blank  = (r_s_en == 4'hF);
    w_bcd    = f_seg_decode(r_s_num[6:0]);
  end

  // Enable decode: exactly one low bit selects a digit slot.
  always_comb begin
    w_legal = 1'b1;
    w_idx   = 2'd0;
    case (r_s_en)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: begin
        w_legal = 1'b0;
        w_idx   = 2'd0;
      end
    endcase
  end

  // Acceptance classification and slot merge for the digit being accepted.
  always_comb begin
    w_dig_acc   = w_accept && !w_blank;
    w_wr        = w_accept && w_legal;
    w_err_inc   = w_dig_acc && (!w_legal || (w_bcd == 4'hF));
    w_wr_bit    = w_wr ? (4'b0001 << w_idx) : 4'b0000;
    w_mask_full = (r_mask == 4'hF);
    w_tmo_hit   = !w_dig_acc && (r_idle == (LP_TMO - 16'd1));
    w_merge_dig = r_slot_dig;
    w_merge_dp  = r_slot_dp;
    if (w_wr) begin
      w_merge_dig[{w_idx, 2'b00} +: 4] = w_bcd;
      w_merge_dp[w_idx]                = ~r_s_num[7];
    end else begin
      w_merge_dig = r_slot_dig;
      w_merge_dp  = r_slot_dp;
    end
    // A frame already waiting in the slots is taken as-is; a frame completed
    // by this edge includes the digit being accepted.
    w_frame_dig = w_mask_full ? r_slot_dig : w_merge_dig;
    w_frame_dp  = w_mask_full ? r_slot_dp  : w_merge_dp;
  end

  // Conversion step: thousands first, acc*10 built from two shifts.
  always_comb begin
    case (r_step)
      2'd0:    w_conv_dig = r_f_dig[15:12];
      2'd1:    w_conv_dig = r_f_dig[11:8];
      2'd2:    w_conv_dig = r_f_dig[7:4];
      2'd3:    w_conv_dig = r_f_dig[3:0];
      default: w_conv_dig = 4'd0;
    endcase
    if (r_f_bad) begin
      w_acc_nxt = 14'd0;
    end else begin
      w_acc_nxt = (r_acc << 3) + (r_acc << 1) + {10'd0, w_conv_dig};
    end
  end

  // Next-state logic; w_start marks the edge that copies a complete frame.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_mask_full || ((r_mask | w_wr_bit) == 4'hF)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CONV;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_CONV: begin
        if (r_step == 2'd3) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CONV;
        end
      end
      ST_DONE: w_state_nxt = ST_COLLECT;
      default: w_state_nxt = ST_COLLECT;
    endcase
    // A waiting full frame must not be overwritten until it is copied.
    w_slot_we = w_wr && (!w_mask_full || w_start);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Input sampling and stability run-length counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_en     <= 4'hF;
      r_s_num    <= 8'hFF;
      r_stab_cnt <= 8'd0;
    end else begin
      r_s_en  <= en;
      r_s_num <= num;
      if (!w_same) begin
        r_stab_cnt <= 8'd1;
      end else if (r_stab_cnt != LP_STABLE) begin
        r_stab_cnt <= r_stab_cnt + 8'd1;
      end
    end
  end

  // Idle timer, stall flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle  <= 16'd0;
      stalled <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      if (w_dig_acc) begin
        r_idle  <= 16'd0;
        stalled <= 1'b0;
      end else if (r_idle != LP_TMO) begin
        r_idle <= r_idle + 16'd1;
        if (w_tmo_hit) begin
          stalled <= 1'b1;
        end
      end
      if (w_err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Collect slots and mask; frame copy clears the mask but keeps any digit
  // accepted on the same edge once the previous frame has been taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_dig <= 16'd0;
      r_slot_dp  <= 4'd0;
      r_mask     <= 4'd0;
    end else begin
      if (w_slot_we) begin
        r_slot_dig <= w_merge_dig;
        r_slot_dp  <= w_merge_dp;
      end
      if (w_tmo_hit) begin
        r_mask <= 4'd0;
      end else if (w_start && w_mask_full) begin
        r_mask <= w_wr_bit;
      end else if (w_start) begin
        r_mask <= 4'd0;
      end else if (w_slot_we) begin
        r_mask <= r_mask | w_wr_bit;
      end
    end
  end

  // Frame capture and binary conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_f_dig <= 16'd0;
      r_f_dp  <= 4'd0;
      r_f_bad <= 1'b0;
      r_acc   <= 14'd0;
      r_step  <= 2'd0;
    end else if (w_start) begin
      r_f_dig <= w_frame_dig;
      r_f_dp  <= w_frame_dp;
      r_f_bad <= f_any_bad(w_frame_dig);
      r_acc   <= 14'd0;
      r_step  <= 2'd0;
    end else if (r_state == ST_CONV) begin
      r_acc  <= w_acc_nxt;
      r_step <= r_step + 2'd1;
    end
  end

  // Published frame outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits      <= 16'd0;
      value       <= 14'd0;
      dp          <= 4'd0;
      bad         <= 1'b0;
      frame_valid <= 1'b0;
    end else if (r_state == ST_DONE) begin
      digits      <= r_f_dig;
      value       <= r_f_bad ? 14'd0 : r_acc;
      dp          <= r_f_dp;
      bad         <= r_f_bad;
      frame_valid <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx: directed scenarios followed by
// randomized scan traffic. Expected frames come from a segment-level model
// that only tracks dwell lengths, acceptance times and digit slots.
module tb_seg_scan_rx;
  localparam int STABLE = 4;
  localparam int TMO    = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic [7:0]  num;
  logic [15:0] digits;
  logic [13:0] value;
  logic [3:0]  dp;
  logic        bad;
  logic        frame_valid;
  logic        stalled;
  logic [7:0]  err_cnt;

  seg_scan_rx #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .num(num),
    .digits(digits), .value(value), .dp(dp), .bad(bad),
    .frame_valid(frame_valid), .stalled(stalled), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [13:0] v;
    logic [3:0]  p;
    logic        b;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  seg_tab [10];
  int          m_dig [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  int          m_err;
  longint      m_time;
  longint      m_last;
  logic [3:0]  p_en;
  logic [7:0]  p_num;

  always @(negedge clk) begin
    if (frame_valid) obs_q.push_back('{d: digits, v: value, p: dp, b: bad});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_decode(input logic [7:0] n8);
    for (int k = 0; k < 10; k++) begin
      logic [7:0] t;
      t = seg_tab[k];
      if (n8[6:0] == t[6:0]) return k;
    end
    return 15;
  endfunction

  function automatic int m_idx(input logic [3:0] e);
    int zeros;
    int pos;
    zeros = 0;
    pos = -1;
    for (int i = 0; i < 4; i++) begin
      if (!e[i]) begin
        zeros++;
        pos = i;
      end
    end
    return (zeros == 1) ? pos : -1;
  endfunction

  task automatic model_accept(input logic [3:0] e, input logic [7:0] n8, input longint at);
    int idx;
    int d;
    frame_t f;
    logic any_bad;
    if (e == 4'hF) return;
    if (at - m_last > TMO) m_mask = 4'd0;
    m_last = at;
    idx = m_idx(e);
    if (idx < 0) begin
      if (m_err < 255) m_err++;
      return;
    end
    d = m_decode(n8);
    if (d == 15 && m_err < 255) m_err++;
    m_dig[idx]  = d;
    m_dp[idx]   = ~n8[7];
    m_mask[idx] = 1'b1;
    if (m_mask == 4'hF) begin
      any_bad = (m_dig[0] == 15) || (m_dig[1] == 15) || (m_dig[2] == 15) || (m_dig[3] == 15);
      f.d = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
      f.v = any_bad ? 14'd0 : 14'(m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0]);
      f.p = m_dp;
      f.b = any_bad;
      exp_q.push_back(f);
      m_mask = 4'd0;
    end
  endtask

  task automatic drive(input logic [3:0] e, input logic [7:0] n8, input int cyc);
    en = e;
    num = n8;
    p_en = e;
    p_num = n8;
    if (cyc >= STABLE) model_accept(e, n8, m_time + STABLE);
    repeat (cyc) @(negedge clk);
    m_time += cyc;
  endtask

  task automatic do_reset();
    en = 4'hF;
    num = 8'hFF;
    p_en = 4'hF;
    p_num = 8'hFF;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_time += 1;
    m_last = m_time;
    m_mask = 4'd0;
    m_err = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Digit patterns with dp off; units are driven first.
  task automatic scan4(input int d3, input int d2, input int d1, input int d0, input bit gaps);
    int dd [4];
    dd = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      drive(~(4'b0001 << i), seg_tab[dd[i]], 8);
      if (gaps) begin
        drive(4'hF, 8'hFF, 3);
        drive(4'b1101, 8'h88, 2);
      end
    end
  endtask

  task automatic compare_frames(input string name);
    frame_t e;
    frame_t o;
    drive(4'hF, 8'hFF, 8);
    check_eq({name, ".nframes"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq({name, ".digits"}, o.d, e.d);
      check_eq({name, ".value"}, o.v, e.v);
      check_eq({name, ".dp"}, o.p, e.p);
      check_eq({name, ".bad"}, o.b, e.b);
    end
    exp_q.delete();
    obs_q.delete();
    check_eq({name, ".err_cnt"}, err_cnt, m_err);
    check_eq({name, ".stalled"}, stalled, (m_time - m_last >= TMO) ? 1 : 0);
  endtask

  task automatic rand_seg();
    logic [3:0] e;
    logic [7:0] n8;
    int cyc;
    int k;
    do begin
      k = $urandom_range(0, 99);
      if (k < 55) begin
        e   = ~(4'b0001 << $urandom_range(0, 3));
        n8  = seg_tab[$urandom_range(0, 9)];
        n8[7] = 1'($urandom);
        cyc = $urandom_range(4, 8);
      end else if (k < 70) begin
        e = 4'hF; n8 = 8'hFF; cyc = $urandom_range(1, 3);
      end else if (k < 85) begin
        e = 4'($urandom); n8 = 8'($urandom); cyc = $urandom_range(1, 3);
      end else if (k < 92) begin
        do e = 4'($urandom); while (m_idx(e) >= 0 || e == 4'hF);
        n8 = 8'($urandom); cyc = $urandom_range(4, 6);
      end else begin
        e = ~(4'b0001 << $urandom_range(0, 3));
        do n8 = 8'($urandom); while (m_decode(n8) != 15);
        cyc = $urandom_range(4, 6);
      end
    end while (e == p_en && n8 == p_num);
    drive(e, n8, cyc);
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    m_time = 0;
    m_last = 0;
    m_err = 0;
    m_mask = 4'd0;
    m_dp = 4'd0;
    rst_n = 1'b0;
    en = 4'hF;
    num = 8'hFF;
    @(negedge clk);
    do_reset();

    check_eq("rst.digits", digits, 16'h0000);
    check_eq("rst.value", value, 14'd0);
    check_eq("rst.dp", dp, 4'd0);
    check_eq("rst.bad", bad, 1'b0);
    check_eq("rst.frame_valid", frame_valid, 1'b0);
    check_eq("rst.stalled", stalled, 1'b0);
    check_eq("rst.err_cnt", err_cnt, 8'd0);

    scan4(1, 2, 3, 4, 1'b0);
    compare_frames("s1234");
    check_eq("s1234.digits_const", digits, 16'h1234);
    check_eq("s1234.value_const", value, 14'd1234);

    scan4(1, 2, 3, 4, 1'b1);
    compare_frames("s1234gap");
    check_eq("s1234gap.err_const", err_cnt, 8'd0);

    do_reset();
    drive(4'b1110, seg_tab[4], 8);
    drive(4'b1101, seg_tab[3], 8);
    drive(4'b1011, seg_tab[2], 8);
    drive(4'b0111, 8'hFF, 8);
    compare_frames("badthou");
    check_eq("badthou.digits_const", digits, 16'hF234);
    check_eq("badthou.bad_const", bad, 1'b1);
    check_eq("badthou.value_const", value, 14'd0);
    check_eq("badthou.err_const", err_cnt, 8'd1);

    do_reset();
    drive(4'b1100, 8'hC0, 10);
    drive(4'b1110, seg_tab[9], 8);
    drive(4'b1101, seg_tab[0] & 8'h7F, 8);
    drive(4'b1011, seg_tab[0], 8);
    drive(4'b0111, seg_tab[0], 8);
    compare_frames("s0009");
    check_eq("s0009.digits_const", digits, 16'h0009);
    check_eq("s0009.value_const", value, 14'd9);
    check_eq("s0009.dp_const", dp, 4'b0010);
    check_eq("s0009.err_const", err_cnt, 8'd1);

    do_reset();
    drive(4'b1110, seg_tab[3], 8);
    drive(4'b1101, seg_tab[2], 8);
    drive(4'b1011, seg_tab[1], 8);
    drive(4'hF, 8'hFF, 11);
    check_eq("tmo.stalled_15", stalled, 1'b0);
    drive(4'hF, 8'hFF, 1);
    check_eq("tmo.stalled_16", stalled, 1'b1);
    check_eq("tmo.no_frame", obs_q.size(), 0);
    scan4(5, 6, 7, 8, 1'b0);
    compare_frames("s5678");
    check_eq("s5678.value_const", value, 14'd5678);
    check_eq("s5678.stalled_const", stalled, 1'b0);

    do_reset();
    drive(4'b1110, seg_tab[9], 8);
    drive(4'b1101, seg_tab[9], 8);
    drive(4'b1011, seg_tab[9], 8);
    drive(4'b0111, seg_tab[9], 6);
    do_reset();
    check_eq("rstconv.digits", digits, 16'h0000);
    check_eq("rstconv.value", value, 14'd0);
    check_eq("rstconv.frame_valid", frame_valid, 1'b0);
    check_eq("rstconv.err_cnt", err_cnt, 8'd0);
    drive(4'hF, 8'hFF, 8);
    check_eq("rstconv.no_frame", obs_q.size(), 0);
    scan4(0, 0, 0, 0, 1'b0);
    check_eq("s0000.nframes_const", obs_q.size() + exp_q.size(), 1);
    compare_frames("s0000");
    check_eq("s0000.value_const", value, 14'd0);

    do_reset();
    for (int s = 0; s < 300; s++) begin
      rand_seg();
      if (s % 50 == 49) compare_frames("rand");
    end
    compare_frames("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_rx.md
# seg_scan_rx

Receive-side decoder for the four-digit multiplexed seven-segment scan bus (active-low digit enables plus active-low segment byte) driven by the meter display logic. It samples the scan bus, filters transitions, maps segment patterns back to BCD digits, assembles a complete four-digit frame and converts it to binary. It serves as a display read-back monitor on the board and as a self-checking capture element in benches.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical samples (2..255) needed to accept an (en, num) pair.
- TIMEOUT_CYCLES, 65535: clocks without an accepted digit before `stalled` asserts (≥16).

Ports:
- clk  in  1  system clock; only clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  4  digit enables, active-low; en[0] = units … en[3] = thousands; 4'b1111 = blank.
- num  in  8  segments, active-low; num[0]=a … num[6]=g, num[7]=dp.
- digits  out  16  BCD frame {thousands, hundreds, tens, units}; 4'hF marks an undecodable digit.
- value  out  14  binary of `digits` (0..9999); 0 when `bad`.
- dp  out  4  decimal-point state per digit, 1 = lit.
- bad  out  1  frame contains ≥1 undecodable digit.
- frame_valid  out  1  one-cycle pulse; `digits/value/dp/bad` updated the same cycle.
- stalled  out  1  level; no digit accepted for TIMEOUT_CYCLES.
- err_cnt  out  8  saturating count of illegal enables and unknown patterns.

## Operation
- Input stage: `en`, `num` registered once (s_en, s_num). A stability counter increments while {s_en, s_num} equals the previous sample, reloads to 1 on change.
- Acceptance: when the counter reaches STABLE_CYCLES, the pair is accepted exactly once per dwell; no re-acceptance until the pair changes.
- s_en = 1111: blank; never accepted, not an error.
- s_en with more than one low bit: not captured; err_cnt +1 on acceptance.
- Decode num[6:0] (active-low): C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9 (values written with bit 7 = 1). Any other pattern → 4'hF, err_cnt +1. dp = ~num[7].
- Accepted digit i is written to collect slot i, and mask[i] is set. A repeat of slot i before the frame completes overwrites it.
- FSM:
  - COLLECT: waits for mask == 4'b1111.
  - On the completing edge: slots are copied to the frame registers, mask is cleared, and the FSM moves to CONV.
  - CONV (4 cycles): acc = acc*10 + digit, thousands first; acc starts at 0. Multiply by 10 as (acc<<3)+(acc<<1), 14-bit. The conversion is skipped arithmetically if any digit is F; the result is then forced to 0.
  - DONE (1 cycle): outputs load, frame_valid = 1, then back to COLLECT.
- Collection continues during CONV/DONE into the cleared mask. Frames never drop digits accepted after completion.
- Timeout: an idle counter clears on every accepted digit (legal or not) and saturates at TIMEOUT_CYCLES.
  - At saturation, stalled = 1, mask is cleared, and partial slots are discarded.
  - stalled drops on the next accepted digit.
- err_cnt saturates at 255. It clears only on reset.

## Timing
- Reset (rst_n low at an edge): digits = 0, value = 0, dp = 0, bad = 0, frame_valid = 0, stalled = 0, err_cnt = 0. Mask, counters and FSM are cleared, and the FSM goes to COLLECT. Reset takes effect mid-CONV; the partial frame is lost.
- Acceptance latency: a pair first present before edge t is registered at t and accepted at edge t+STABLE_CYCLES−1.
- Frame latency: if the completing digit is accepted at edge A, CONV runs on A+1..A+4 and frame_valid is high for the cycle after edge A+5. Outputs hold until the next frame.
- Minimum frame spacing is 6 cycles. A frame completing during CONV/DONE is held in COLLECT and starts CONV on the cycle after DONE; its slots are not overwritten while waiting.
- Dwell shorter than STABLE_CYCLES: ignored entirely.

## Test plan
- Scan 1234 (units en=1110/num=A4-style patterns for 4,3,2,1), dwell 8 clocks each, STABLE_CYCLES=4 → one frame_valid; digits=16'h1234, value=1234, bad=0, err_cnt=0.
- Same scan with 1111 blanking gaps of 3 clocks and 2-clock glitch patterns between digits → identical frame; glitches are neither decoded nor counted.
- Thousands digit pattern 8'hFF (all segments off, not blank en) → digits=16'hF234, bad=1, value=0, err_cnt=1.
- en=1100 held 10 clocks, then a valid frame 0009 with dp on tens → err_cnt=1, digits=16'h0009, value=9, dp=4'b0010.
- Three digits then bus idle for TIMEOUT_CYCLES=16 → stalled=1 at the 16th idle clock, no frame. A following full scan of 5678 → stalled=0, value=5678.
- rst_n low for 1 edge during CONV of 9999 → no frame_valid, all outputs 0. The next full scan of 0000 → value=0, frame_valid once.
